mem_wb_writeback: RTL and testbench

- MEM/WB pipeline stage for the five-stage MIPS core; the writer side of the register-file write port (waddr/wdata/we).
- Latches the MEM-stage result and aligns/extends load data from data memory.
- Presents a registered write request to the register file every cycle.
- Honours pipeline stall and flush so that each retired instruction writes the register file exactly once.

---
 rtl/mem_wb_writeback_pkg.sv | 24 ++
 rtl/mem_wb_writeback_load_align.sv | 46 ++++
 rtl/mem_wb_writeback.sv | 87 ++++++++
 tb/tb_mem_wb_writeback.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_writeback_pkg.sv
// Shared definitions for the MEM/WB writeback stage: load-op codes and constants.
package mem_wb_writeback_pkg;

    // Load type encodings carried on mem_load_op; codes 5..7 are reserved.
    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LBU = 3'd1;
    localparam logic [2:0] LOAD_LH  = 3'd2;
    localparam logic [2:0] LOAD_LHU = 3'd3;
    localparam logic [2:0] LOAD_LW  = 3'd4;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    // Extend a byte to a word, sign- or zero-filling the upper bits.
    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    // Extend a halfword to a word, sign- or zero-filling the upper bits.
    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_wb_writeback_load_align.sv
// Big-endian load alignment and extension; flags misaligned halfword/word loads.
module mem_wb_writeback_load_align
    import mem_wb_writeback_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Byte 0 is the most significant byte of the word.
    always_comb begin
        sel_byte = rdata[31:24];
        unique case (addr_lo)
            2'd0: sel_byte = rdata[31:24];
            2'd1: sel_byte = rdata[23:16];
            2'd2: sel_byte = rdata[15:8];
            2'd3: sel_byte = rdata[7:0];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Pick and extend the addressed field; misaligned accesses pass the raw word.
    always_comb begin
        data     = rdata;
        misalign = 1'b0;
        case (load_op)
            LOAD_LB:  data = ext_byte(sel_byte, 1'b1);
            LOAD_LBU: data = ext_byte(sel_byte, 1'b0);
            LOAD_LH, LOAD_LHU: begin
                misalign = addr_lo[0];
                if (!addr_lo[0]) begin
                    data = ext_half(sel_half, load_op == LOAD_LH);
                end
            end
            // LW and the reserved codes share word behaviour.
            default: misalign = (addr_lo != 2'd0);
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register: captures the MEM result, aligns loads, and drives the
// register-file write port under stall/flush control.
module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              mem_is_load,
    input  logic [2:0]        mem_load_op,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_misalign
);

    logic [DATA_W-1:0] align_data;
    logic              align_misalign;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              misalign_q, misalign_d;

    logic              load_bad;

    mem_wb_writeback_load_align u_load_align (
        .load_op  (mem_load_op),
        .addr_lo  (mem_addr_lo),
        .rdata    (mem_rdata),
        .data     (align_data),
        .misalign (align_misalign)
    );

    assign load_bad = mem_is_load & align_misalign;

    // Next-state: flush beats a MEM-only stall (bubble), which beats a WB hold.
    always_comb begin
        we_d       = we_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        misalign_d = misalign_q;
        if (flush || (stall_mem && !stall_wb)) begin
            we_d       = 1'b0;
            waddr_d    = '0;
            wdata_d    = ZERO_WORD;
            misalign_d = 1'b0;
        end else if (!stall_wb) begin
            // r0 is hardwired; its index/data are still latched for visibility.
            we_d       = mem_we && (mem_waddr != ADDR_W'(REG_ZERO)) && !load_bad;
            waddr_d    = mem_waddr;
            wdata_d    = mem_is_load ? align_data : mem_result;
            misalign_d = load_bad;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= ZERO_WORD;
            misalign_q <= 1'b0;
        end else begin
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign wb_we       = we_q;
    assign wb_waddr    = waddr_q;
    assign wb_wdata    = wdata_q;
    assign wb_misalign = misalign_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback with a scoreboard of expected WB outputs.
module tb_mem_wb_writeback;
    import mem_wb_writeback_pkg::*;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        misalign;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_result;
    logic        mem_is_load;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_misalign;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    localparam logic [31:0] RD = 32'h80FF_7F01;

    mem_wb_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_result  (mem_result),
        .mem_is_load (mem_is_load),
        .mem_load_op (mem_load_op),
        .mem_addr_lo (mem_addr_lo),
        .mem_rdata   (mem_rdata),
        .stall_mem   (stall_mem),
        .stall_wb    (stall_wb),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .wb_misalign (wb_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        rst = 1'b0; mem_we = 1'b0; mem_waddr = 5'd0; mem_result = 32'd0;
        mem_is_load = 1'b0; mem_load_op = LOAD_LW; mem_addr_lo = 2'd0; mem_rdata = 32'd0;
        stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
    endtask

    task automatic expect_out(input logic we, input logic [4:0] a, input logic [31:0] d,
                              input logic mis, input string tag);
        exp_t e;
        e.we = we; e.waddr = a; e.wdata = d; e.misalign = mis;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Drive a load with the fixed test word into register 9.
    task automatic load(input logic [2:0] op, input logic [1:0] lo);
        idle();
        mem_we = 1'b1; mem_waddr = 5'd9; mem_is_load = 1'b1;
        mem_load_op = op; mem_addr_lo = lo; mem_rdata = RD; mem_result = 32'hDEAD_BEEF;
    endtask

    // Advance one edge, then compare the DUT against the oldest expectation.
    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: got=empty exp=entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            assert (wb_we === e.we) else begin
                bad++;
                $error("FAIL %s wb_we got=%0h exp=%0h", t, wb_we, e.we);
            end
            total++;
            assert (wb_waddr === e.waddr) else begin
                bad++;
                $error("FAIL %s wb_waddr got=%0d exp=%0d", t, wb_waddr, e.waddr);
            end
            total++;
            assert (wb_wdata === e.wdata) else begin
                bad++;
                $error("FAIL %s wb_wdata got=%08h exp=%08h", t, wb_wdata, e.wdata);
            end
            total++;
            assert (wb_misalign === e.misalign) else begin
                bad++;
                $error("FAIL %s wb_misalign got=%0h exp=%0h", t, wb_misalign, e.misalign);
            end
        end
    endtask

    initial begin
        idle();
        @(negedge clk);

        // Reset with live inputs.
        rst = 1'b1; mem_we = 1'b1; mem_waddr = 5'd5; mem_result = 32'h5555_5555;
        expect_out(1'b0, 5'd0, 32'd0, 1'b0, "reset0"); tick();
        expect_out(1'b0, 5'd0, 32'd0, 1'b0, "reset1"); tick();

        // Non-load pass-through, then r0 suppression.
        idle(); mem_we = 1'b1; mem_waddr = 5'd8; mem_result = 32'h1234_5678;
        expect_out(1'b1, 5'd8, 32'h1234_5678, 1'b0, "pass"); tick();
        mem_waddr = 5'd0;
        expect_out(1'b0, 5'd0, 32'h1234_5678, 1'b0, "r0"); tick();

        // Byte and halfword alignment.
        load(LOAD_LB, 2'd0);  expect_out(1'b1, 5'd9, 32'hFFFF_FF80, 1'b0, "lb0");  tick();
        load(LOAD_LBU, 2'd1); expect_out(1'b1, 5'd9, 32'h0000_00FF, 1'b0, "lbu1"); tick();
        load(LOAD_LB, 2'd2);  expect_out(1'b1, 5'd9, 32'h0000_007F, 1'b0, "lb2");  tick();
        load(LOAD_LBU, 2'd3); expect_out(1'b1, 5'd9, 32'h0000_0001, 1'b0, "lbu3"); tick();
        load(LOAD_LH, 2'd2);  expect_out(1'b1, 5'd9, 32'h0000_7F01, 1'b0, "lh2");  tick();
        load(LOAD_LHU, 2'd0); expect_out(1'b1, 5'd9, 32'h0000_80FF, 1'b0, "lhu0"); tick();
        load(LOAD_LH, 2'd0);  expect_out(1'b1, 5'd9, 32'hFFFF_80FF, 1'b0, "lh0");  tick();

        // Misaligned loads suppress the write and pass the raw word.
        load(LOAD_LW, 2'd2);  expect_out(1'b0, 5'd9, RD, 1'b1, "lw2mis");  tick();
        load(LOAD_LH, 2'd1);  expect_out(1'b0, 5'd9, RD, 1'b1, "lh1mis");  tick();
        load(LOAD_LHU, 2'd3); expect_out(1'b0, 5'd9, RD, 1'b1, "lhu3mis"); tick();
        load(LOAD_LW, 2'd0);  expect_out(1'b1, 5'd9, RD, 1'b0, "lw0");     tick();

        // Reserved codes behave as LW.
        load(3'd7, 2'd0); expect_out(1'b1, 5'd9, RD, 1'b0, "rsv_ok");  tick();
        load(3'd5, 2'd1); expect_out(1'b0, 5'd9, RD, 1'b1, "rsv_mis"); tick();

        // Stall: capture A, hold it 3 cycles while B waits in MEM.
        idle(); mem_we = 1'b1; mem_waddr = 5'd3; mem_result = 32'hAAAA_0003;
        expect_out(1'b1, 5'd3, 32'hAAAA_0003, 1'b0, "capA"); tick();
        mem_waddr = 5'd4; mem_result = 32'hBBBB_0004; stall_wb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out(1'b1, 5'd3, 32'hAAAA_0003, 1'b0, "holdA"); tick();
        end
        stall_wb = 1'b0; stall_mem = 1'b1;
        expect_out(1'b0, 5'd0, 32'd0, 1'b0, "bubble"); tick();
        stall_mem = 1'b0;
        expect_out(1'b1, 5'd4, 32'hBBBB_0004, 1'b0, "capB"); tick();
        mem_we = 1'b0; mem_waddr = 5'd7; mem_result = 32'hCCCC_0007;
        expect_out(1'b0, 5'd7, 32'hCCCC_0007, 1'b0, "capC"); tick();

        // Both stalls together: WB hold wins over the bubble.
        stall_mem = 1'b1; stall_wb = 1'b1; mem_we = 1'b1; mem_waddr = 5'd2;
        expect_out(1'b0, 5'd7, 32'hCCCC_0007, 1'b0, "holdboth"); tick();

        // Misalign flag is held under stall_wb and cleared by flush.
        load(LOAD_LW, 2'd1); expect_out(1'b0, 5'd9, RD, 1'b1, "mis"); tick();
        stall_wb = 1'b1;     expect_out(1'b0, 5'd9, RD, 1'b1, "mishold"); tick();

        // Flush beats stall and a valid write.
        idle(); flush = 1'b1; stall_wb = 1'b1; mem_we = 1'b1; mem_waddr = 5'd6;
        mem_result = 32'h6666_0006;
        expect_out(1'b0, 5'd0, 32'd0, 1'b0, "flush"); tick();
        flush = 1'b0; stall_wb = 1'b0;
        expect_out(1'b1, 5'd6, 32'h6666_0006, 1'b0, "resume"); tick();

        // Reset beats everything.
        rst = 1'b1; flush = 1'b1; stall_wb = 1'b1;
        expect_out(1'b0, 5'd0, 32'd0, 1'b0, "rstprio"); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
